dsp_voice_scheduler: RTL and testbench
======================================

DSP_VOICE_SCHEDULER -- requirements
Module: dsp_voice_scheduler

Interface
REQ-001 SHALL have parameter VOICES, default 8, number of voice decoders served (2..8).
REQ-002 SHALL have parameter ADDR_W, default 16, RAM address width.
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sample_tick  input  1  one-cycle pulse, start of an output sample period.
REQ-006 SHALL have port advance_trigger  output  VOICES  one-hot per-voice advance pulse.
REQ-007 SHALL have port voice_req  input  VOICES  per-voice RAM read request, level.
REQ-008 SHALL have port voice_addr  input  VOICES*ADDR_W  per-voice read address; voice i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port voice_ack  output  VOICES  one-hot, pulses in the cycle a voice's request is issued to RAM.
REQ-010 SHALL have port voice_data  output  8  RAM read data, broadcast to all voices.
REQ-011 SHALL have port voice_valid  output  VOICES  one-hot, marks voice_data as belonging to that voice.
REQ-012 SHALL have port ram_address  output  ADDR_W  shared RAM address.
REQ-013 SHALL have port ram_read_request  output  1  shared RAM read strobe.
REQ-014 SHALL have port ram_data  input  8  shared RAM read data, valid exactly 1 cycle after ram_read_request.
REQ-015 SHALL have port overrun  output  1  sticky flag: sample_tick lost.

Function
REQ-016 Sweep FSM SHALL have states IDLE and SWEEP with a voice counter vcnt.
REQ-017 IDLE: on sample_tick SHALL go to SWEEP with vcnt=0.
REQ-018 SWEEP: SHALL assert advance_trigger[vcnt] for exactly one cycle, then increment vcnt; after vcnt==VOICES-1 SHALL return to IDLE, or restart SWEEP at vcnt=0 if pending set (pending cleared).
REQ-019 sample_tick during SWEEP SHALL set pending; sample_tick while pending already set SHALL set overrun and be dropped.
REQ-020 sample_tick in the final SWEEP cycle SHALL set pending (restart follows immediately, no IDLE cycle).
REQ-021 Arbiter SHALL, each cycle, choose one set bit of voice_req, assert ram_read_request=1, drive ram_address with that voice's address, and pulse voice_ack for it in the same cycle (combinational issue).
REQ-022 No request set: ram_read_request=0, voice_ack=0, ram_address holds last value.
REQ-023 Default arbitration SHALL be round-robin: search starts at last granted index+1, wrapping VOICES-1 -> 0.
REQ-024 One cycle after an issue, voice_data SHALL equal ram_data and voice_valid SHALL be the previous voice_ack; otherwise voice_valid=0.
REQ-025 Reads SHALL be fully pipelined: back-to-back issues every cycle, one read in flight at most per cycle.
REQ-026 A voice holding voice_req after ack SHALL be treated as a new request and compete again.
REQ-027 A voice whose advance_trigger fires in the same cycle as its ack SHALL receive both; no interaction between FSM and arbiter.

Reset
REQ-028 Reset assertion SHALL asynchronously force: advance_trigger=0, voice_valid=0, voice_data=0, overrun=0, pending=0, FSM=IDLE, vcnt=0, round-robin pointer=VOICES-1 (voice 0 first), ram_address=0.
REQ-029 Reset mid-sweep or with read in flight SHALL discard that read; no voice_valid after reset release.
REQ-030 ram_read_request and voice_ack SHALL be 0 while reset is asserted.
REQ-031 overrun SHALL clear only by reset.

Configuration
REQ-032 Macro DSP_SCHED_FIXED_PRIORITY_EN defined: arbitration SHALL be fixed priority, lowest index wins, pointer unused.
REQ-033 Macro undefined: round-robin per REQ-023.

Verification
REQ-034 Reset release, sample_tick at cycle 0 -> advance_trigger = 0x01,0x02,...,0x80 on cycles 1..8, then 0.
REQ-035 voice_req=0xFF held, ram_data=address low byte -> voice_ack 0x01,0x02,...,0x80,0x01; voice_valid same sequence one cycle later with matching data.
REQ-036 voice_req=0x81 held -> ack alternates 0x01,0x80; with DSP_SCHED_FIXED_PRIORITY_EN -> always 0x01.
REQ-037 sample_tick at sweep cycles 3 and 5 -> second sweep starts immediately after first, overrun=1, no third sweep.
REQ-038 reset asserted during sweep cycle 4 with voice 2 read issued -> all outputs 0 immediately; no voice_valid after release.

Source files
------------

// File: rtl/dsp_voice_scheduler_if.sv
// Voice/RAM bus bundle for dsp_voice_scheduler.
// The slave modport is the scheduler side; the master modport is the voices plus RAM.
interface dsp_voice_scheduler_if #(
  parameter int VOICES = 8,
  parameter int ADDR_W = 16
);
  logic [VOICES-1:0]        voice_req;
  logic [VOICES*ADDR_W-1:0] voice_addr;
  logic [VOICES-1:0]        voice_ack;
  logic [7:0]               voice_data;
  logic [VOICES-1:0]        voice_valid;
  logic [ADDR_W-1:0]        ram_address;
  logic                     ram_read_request;
  logic [7:0]               ram_data;

  modport slave (
    input  voice_req, voice_addr, ram_data,
    output voice_ack, voice_data, voice_valid, ram_address, ram_read_request
  );

  modport master (
    output voice_req, voice_addr, ram_data,
    input  voice_ack, voice_data, voice_valid, ram_address, ram_read_request
  );
endinterface

// File: rtl/dsp_voice_scheduler.sv
// Per-sample voice advance sweep plus a shared-RAM read arbiter for the voice decoders.
// Define DSP_SCHED_FIXED_PRIORITY_EN for fixed lowest-index priority instead of round-robin.
module dsp_voice_scheduler #(
  parameter int VOICES = 8,
  parameter int ADDR_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sample_tick,
  output logic [VOICES-1:0]   advance_trigger,
  output logic                overrun,
  dsp_voice_scheduler_if.slave bus
);
  localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [VW-1:0] LAST_V = VW'(VOICES - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  function automatic logic [VOICES-1:0] onehot(input logic [VW-1:0] idx);
    return {{(VOICES-1){1'b0}}, 1'b1} << idx;
  endfunction

  state_t             state_r, state_s;
  logic [VW-1:0]      vcnt_r, vcnt_s;
  logic               pending_r, pending_s;
  logic               overrun_r, overrun_s;
  logic [VOICES-1:0]  adv_r, adv_s;

  logic               found_s;
  logic               issue_s;
  logic [VW-1:0]      grant_idx_s;
  logic [VOICES-1:0]  ack_s;
  logic [ADDR_W-1:0]  addr_s;
  logic [ADDR_W-1:0]  last_addr_r;
  logic [VOICES-1:0]  valid_r;

  // Sweep sequencing: a tick landing on the last voice restarts without an IDLE gap.
  always_comb begin
    state_s   = state_r;
    vcnt_s    = vcnt_r;
    pending_s = pending_r;
    overrun_s = overrun_r;
    adv_s     = {VOICES{1'b0}};
    case (state_r)
      IDLE: begin
        if (sample_tick) begin
          state_s = SWEEP;
          vcnt_s  = {VW{1'b0}};
          adv_s   = onehot({VW{1'b0}});
        end else begin
          state_s = IDLE;
        end
      end
      SWEEP: begin
        if (vcnt_r == LAST_V) begin
          if (pending_r || sample_tick) begin
            state_s   = SWEEP;
            vcnt_s    = {VW{1'b0}};
            adv_s     = onehot({VW{1'b0}});
            pending_s = 1'b0;
            if (pending_r && sample_tick) begin
              overrun_s = 1'b1;
            end else begin
              overrun_s = overrun_r;
            end
          end else begin
            state_s = IDLE;
          end
        end else begin
          vcnt_s = vcnt_r + {{(VW-1){1'b0}}, 1'b1};
          adv_s  = onehot(vcnt_s);
          if (sample_tick) begin
            if (pending_r) begin
              overrun_s = 1'b1;
            end else begin
              pending_s = 1'b1;
            end
          end else begin
            pending_s = pending_r;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Sweep state register and registered advance/overrun outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      vcnt_r    <= {VW{1'b0}};
      pending_r <= 1'b0;
      overrun_r <= 1'b0;
      adv_r     <= {VOICES{1'b0}};
    end else begin
      state_r   <= state_s;
      vcnt_r    <= vcnt_s;
      pending_r <= pending_s;
      overrun_r <= overrun_s;
      adv_r     <= adv_s;
    end
  end

`ifdef DSP_SCHED_FIXED_PRIORITY_EN
  // Fixed priority: scanning downward leaves the lowest requesting index as winner.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = {VW{1'b0}};
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (bus.voice_req[i]) begin
        found_s     = 1'b1;
        grant_idx_s = VW'(i);
      end else begin
        found_s     = found_s;
      end
    end
  end
`else
  logic [VW-1:0] ptr_r;

  // Round-robin: search begins one past the last granted voice and wraps.
  always_comb begin
    int cand;
    found_s     = 1'b0;
    grant_idx_s = ptr_r;
    cand        = 0;
    for (int i = 1; i <= VOICES; i++) begin
      cand = int'(ptr_r) + i;
      if (cand >= VOICES) begin
        cand = cand - VOICES;
      end else begin
        cand = cand;
      end
      if (!found_s && bus.voice_req[cand]) begin
        found_s     = 1'b1;
        grant_idx_s = VW'(cand);
      end else begin
        found_s     = found_s;
      end
    end
  end

  // Pointer starts at the top index so voice 0 is served first after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_r <= LAST_V;
    end else if (issue_s) begin
      ptr_r <= grant_idx_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

  // Issue is gated by reset so no strobe or ack escapes while reset is held.
  always_comb begin
    issue_s = found_s & reset;
    if (issue_s) begin
      ack_s  = onehot(grant_idx_s);
      addr_s = bus.voice_addr[grant_idx_s*ADDR_W +: ADDR_W];
    end else begin
      ack_s  = {VOICES{1'b0}};
      addr_s = last_addr_r;
    end
  end

  // Remember the issued address and which voice owns next cycle's RAM data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_addr_r <= {ADDR_W{1'b0}};
      valid_r     <= {VOICES{1'b0}};
    end else begin
      last_addr_r <= addr_s;
      valid_r     <= ack_s;
    end
  end

  assign advance_trigger      = adv_r;
  assign overrun              = overrun_r;
  assign bus.voice_ack        = ack_s;
  assign bus.ram_read_request = issue_s;
  assign bus.ram_address      = addr_s;
  assign bus.voice_valid      = valid_r;
  // RAM data arrives one cycle after issue, so it is forwarded rather than re-registered.
  assign bus.voice_data       = (|valid_r) ? bus.ram_data : 8'h00;
endmodule

// File: tb/tb_dsp_voice_scheduler.sv
// Scoreboard bench for dsp_voice_scheduler: sweep timing, overrun, arbitration and reset.
module tb_dsp_voice_scheduler;
  localparam int VOICES = 8;
  localparam int ADDR_W = 16;

  logic              clock;
  logic              reset;
  logic              sample_tick;
  logic [VOICES-1:0] advance_trigger;
  logic              overrun;

  dsp_voice_scheduler_if #(.VOICES(VOICES), .ADDR_W(ADDR_W)) bus ();

  dsp_voice_scheduler #(.VOICES(VOICES), .ADDR_W(ADDR_W)) dut (
    .clock           (clock),
    .reset           (reset),
    .sample_tick     (sample_tick),
    .advance_trigger (advance_trigger),
    .overrun         (overrun),
    .bus             (bus)
  );

  typedef struct {
    logic [7:0] valid;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_err;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model: returns the low address byte one cycle after each read strobe.
  always @(posedge clock) begin
    if (bus.ram_read_request) bus.ram_data <= bus.ram_address[7:0];
    else                      bus.ram_data <= 8'h00;
  end

  function automatic logic [15:0] addr_of(input int i);
    return {8'(8'hA0 + i), 8'(17 * (i + 1))};
  endfunction

  task automatic test_reset();
    reset            = 1'b0;
    sample_tick      = 1'b0;
    bus.voice_req    = 8'hFF;
    for (int i = 0; i < VOICES; i++) bus.voice_addr[i*ADDR_W +: ADDR_W] = addr_of(i);
    repeat (2) @(negedge clock);
    n_cmp++; if (advance_trigger !== 8'h00) begin n_err++; $display("FAIL reset_adv got %h want 00", advance_trigger); end
    n_cmp++; if (bus.voice_ack !== 8'h00) begin n_err++; $display("FAIL reset_ack got %h want 00", bus.voice_ack); end
    n_cmp++; if (bus.ram_read_request !== 1'b0) begin n_err++; $display("FAIL reset_rrq got %b want 0", bus.ram_read_request); end
    n_cmp++; if (bus.voice_valid !== 8'h00 || bus.voice_data !== 8'h00) begin n_err++; $display("FAIL reset_valid got %h/%h want 00/00", bus.voice_valid, bus.voice_data); end
    n_cmp++; if (overrun !== 1'b0 || bus.ram_address !== 16'h0000) begin n_err++; $display("FAIL reset_ovr_addr got %b/%h want 0/0000", overrun, bus.ram_address); end
    bus.voice_req = 8'h00;
    reset         = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_sweep();
    sample_tick = 1'b1;
    @(negedge clock);
    sample_tick = 1'b0;
    for (int k = 0; k < VOICES; k++) begin
      n_cmp++; if (advance_trigger !== 8'(8'h01 << k)) begin n_err++; $display("FAIL sweep_adv k=%0d got %h want %h", k, advance_trigger, 8'(8'h01 << k)); end
      @(negedge clock);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (advance_trigger !== 8'h00) begin n_err++; $display("FAIL sweep_idle got %h want 00", advance_trigger); end
      @(negedge clock);
    end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL sweep_ovr got %b want 0", overrun); end
  endtask

  task automatic test_final_tick();
    sample_tick = 1'b1;
    @(negedge clock);
    for (int k = 0; k < 2 * VOICES; k++) begin
      sample_tick = (k == VOICES - 1);
      n_cmp++; if (advance_trigger !== 8'(8'h01 << (k % VOICES))) begin n_err++; $display("FAIL final_adv k=%0d got %h want %h", k, advance_trigger, 8'(8'h01 << (k % VOICES))); end
      @(negedge clock);
    end
    sample_tick = 1'b0;
    n_cmp++; if (advance_trigger !== 8'h00 || overrun !== 1'b0) begin n_err++; $display("FAIL final_end got %h/%b want 00/0", advance_trigger, overrun); end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_overrun();
    sample_tick = 1'b1;
    @(negedge clock);
    for (int k = 0; k < 2 * VOICES; k++) begin
      if (k == 4) begin
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_early got %b want 0", overrun); end
      end
      sample_tick = (k == 2 || k == 4);
      n_cmp++; if (advance_trigger !== 8'(8'h01 << (k % VOICES))) begin n_err++; $display("FAIL ovr_adv k=%0d got %h want %h", k, advance_trigger, 8'(8'h01 << (k % VOICES))); end
      @(negedge clock);
    end
    sample_tick = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (advance_trigger !== 8'h00 || overrun !== 1'b1) begin n_err++; $display("FAIL ovr_after got %h/%b want 00/1", advance_trigger, overrun); end
      @(negedge clock);
    end
  endtask

  task automatic test_rr_pair();
    exp_t       e;
    logic [7:0] want;
    bus.voice_req = 8'h81;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++; if (bus.voice_valid !== e.valid || bus.voice_data !== e.data) begin n_err++; $display("FAIL pair_valid got %h/%h want %h/%h", bus.voice_valid, bus.voice_data, e.valid, e.data); end
      end
`ifdef DSP_SCHED_FIXED_PRIORITY_EN
      want = 8'h01;
`else
      want = (c % 2 == 0) ? 8'h01 : 8'h80;
`endif
      n_cmp++; if (bus.voice_ack !== want || bus.ram_read_request !== 1'b1) begin n_err++; $display("FAIL pair_ack c=%0d got %h/%b want %h/1", c, bus.voice_ack, bus.ram_read_request, want); end
      e.valid = want;
      e.data  = (want == 8'h01) ? 8'h11 : 8'h88;
      exp_q.push_back(e);
      @(negedge clock);
    end
    e = exp_q.pop_front();
    n_cmp++; if (bus.voice_valid !== e.valid || bus.voice_data !== e.data) begin n_err++; $display("FAIL pair_drain got %h/%h want %h/%h", bus.voice_valid, bus.voice_data, e.valid, e.data); end
    bus.voice_req = 8'h00;
    #1;
    n_cmp++; if (bus.voice_ack !== 8'h00 || bus.ram_read_request !== 1'b0) begin n_err++; $display("FAIL pair_noreq got %h/%b want 00/0", bus.voice_ack, bus.ram_read_request); end
    @(negedge clock);
    n_cmp++; if (bus.voice_valid !== 8'h00) begin n_err++; $display("FAIL pair_novalid got %h want 00", bus.voice_valid); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   idx;
    bus.voice_req = 8'hFF;
    for (int c = 0; c <= VOICES; c++) begin
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++; if (bus.voice_valid !== e.valid || bus.voice_data !== e.data) begin n_err++; $display("FAIL b2b_valid c=%0d got %h/%h want %h/%h", c, bus.voice_valid, bus.voice_data, e.valid, e.data); end
      end
`ifdef DSP_SCHED_FIXED_PRIORITY_EN
      idx = 0;
`else
      idx = c % VOICES;
`endif
      n_cmp++; if (bus.voice_ack !== 8'(8'h01 << idx) || bus.ram_address !== addr_of(idx)) begin n_err++; $display("FAIL b2b_ack c=%0d got %h/%h want %h/%h", c, bus.voice_ack, bus.ram_address, 8'(8'h01 << idx), addr_of(idx)); end
      e.valid = 8'(8'h01 << idx);
      e.data  = 8'(17 * (idx + 1));
      exp_q.push_back(e);
      @(negedge clock);
    end
    e = exp_q.pop_front();
    n_cmp++; if (bus.voice_valid !== e.valid || bus.voice_data !== e.data) begin n_err++; $display("FAIL b2b_drain got %h/%h want %h/%h", bus.voice_valid, bus.voice_data, e.valid, e.data); end
    bus.voice_req = 8'h00;
    #1;
    n_cmp++; if (bus.ram_read_request !== 1'b0 || bus.ram_address !== addr_of(0)) begin n_err++; $display("FAIL b2b_hold got %b/%h want 0/%h", bus.ram_read_request, bus.ram_address, addr_of(0)); end
    @(negedge clock);
  endtask

  task automatic test_reset_midsweep();
    sample_tick = 1'b1;
    @(negedge clock);
    sample_tick = 1'b0;
    repeat (3) @(negedge clock);
    bus.voice_req = 8'h04;
    #1;
    n_cmp++; if (advance_trigger !== 8'h08 || bus.voice_ack !== 8'h04) begin n_err++; $display("FAIL mid_both got %h/%h want 08/04", advance_trigger, bus.voice_ack); end
    @(posedge clock);
    #1;
    n_cmp++; if (bus.voice_valid !== 8'h04) begin n_err++; $display("FAIL mid_inflight got %h want 04", bus.voice_valid); end
    reset = 1'b0;
    #1;
    n_cmp++; if (advance_trigger !== 8'h00 || bus.voice_ack !== 8'h00 || bus.ram_read_request !== 1'b0) begin n_err++; $display("FAIL mid_rst_a got %h/%h/%b want 00/00/0", advance_trigger, bus.voice_ack, bus.ram_read_request); end
    n_cmp++; if (bus.voice_valid !== 8'h00 || bus.voice_data !== 8'h00 || overrun !== 1'b0 || bus.ram_address !== 16'h0000) begin n_err++; $display("FAIL mid_rst_b got %h/%h/%b/%h want 00/00/0/0000", bus.voice_valid, bus.voice_data, overrun, bus.ram_address); end
    bus.voice_req = 8'h00;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      n_cmp++; if (bus.voice_valid !== 8'h00 || advance_trigger !== 8'h00) begin n_err++; $display("FAIL mid_after got %h/%h want 00/00", bus.voice_valid, advance_trigger); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_sweep();
    test_final_tick();
    test_overrun();
    test_rr_pair();
    test_back_to_back();
    test_reset_midsweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
